// File: rtl/seq_mem_scan_reader_pkg.sv
// seq_scan_pkg: shared defaults, FSM state type and width helpers for the scan reader
package seq_scan_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_ADDR_W:0] len_t;
endpackage

// File: rtl/seq_mem_scan_reader_if.sv
// seq_mem_scan_reader_if: write ports, scan control and output stream of the scan reader
interface seq_mem_scan_reader_if import seq_scan_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BIT_W = $clog2(DATA_W)
);
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic bit_en;
  logic [ADDR_W-1:0] bit_addr;
  logic [BIT_W-1:0] bit_index;
  logic bit_value;
  logic start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0] length;
  logic busy;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic out_last;
  logic done;
  modport slave (
    input wr_en, wr_addr, wr_data, bit_en, bit_addr, bit_index, bit_value,
    input start, start_addr, length, out_ready,
    output busy, out_valid, out_data, out_addr, out_last, done
  );
  modport master (
    output wr_en, wr_addr, wr_data, bit_en, bit_addr, bit_index, bit_value,
    output start, start_addr, length, out_ready,
    input busy, out_valid, out_data, out_addr, out_last, done
  );
endinterface

// File: rtl/seq_mem_scan_reader_mem.sv
// seq_scan_mem: DEPTH x DATA_W array, word + bit write ports, one enabled sync read port
module seq_scan_mem import seq_scan_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BIT_W = $clog2(DATA_W)
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic i_bit_en,
  input  logic [ADDR_W-1:0] i_bit_addr,
  input  logic [BIT_W-1:0] i_bit_index,
  input  logic i_bit_value,
  input  logic i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  // bit write is ordered after the word write so it wins on a shared bit
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_bit_en) r_mem[i_bit_addr][i_bit_index] <= i_bit_value;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/seq_mem_scan_reader.sv
// seq_mem_scan_reader: FSM sweeps an address range through the memory and streams words out
module seq_mem_scan_reader import seq_scan_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BIT_W = $clog2(DATA_W)
)(
  input logic clk,
  input logic rst_n,
  seq_mem_scan_reader_if.slave bus
);
  scan_state_t r_state, w_next;
  logic [ADDR_W-1:0] r_cur, r_out_addr, w_cur_inc;
  logic [ADDR_W:0] r_rem, w_len;
  logic r_valid, r_last, w_issue, w_xfer;
  logic [DATA_W-1:0] w_rd_data;
  assign w_xfer = r_valid && bus.out_ready;
  assign w_issue = (r_state == SCAN) && (r_rem != '0) && (!r_valid || bus.out_ready);
  assign w_len = (bus.length > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.length;
  assign w_cur_inc = (r_cur == ADDR_W'(DEPTH-1)) ? '0 : r_cur + ADDR_W'(1);
  always_comb
    w_next = (r_state == IDLE) ? (bus.start ? ((w_len == '0) ? DONE : SCAN) : IDLE) :
             (r_state == SCAN) ? ((w_xfer && r_last) ? DONE : SCAN) : IDLE;
  seq_scan_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BIT_W(BIT_W)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .i_wr_en(bus.wr_en),
    .i_wr_addr(bus.wr_addr),
    .i_wr_data(bus.wr_data),
    .i_bit_en(bus.bit_en),
    .i_bit_addr(bus.bit_addr),
    .i_bit_index(bus.bit_index),
    .i_bit_value(bus.bit_value),
    .i_rd_en(w_issue),
    .i_rd_addr(r_cur),
    .o_rd_data(w_rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cur <= '0;
      r_rem <= '0;
      r_out_addr <= '0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_cur <= bus.start_addr;
        r_rem <= w_len;
      end
      if (w_issue) begin
        r_cur <= w_cur_inc;
        r_rem <= r_rem - (ADDR_W+1)'(1);
        r_out_addr <= r_cur;
        r_last <= (r_rem == (ADDR_W+1)'(1));
        r_valid <= 1'b1;
      end else if (w_xfer) r_valid <= 1'b0;
    end
  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.out_valid = r_valid;
  assign bus.out_data = w_rd_data;
  assign bus.out_addr = r_out_addr;
  assign bus.out_last = r_last;
endmodule

// File: tb/tb_seq_mem_scan_reader.sv
// tb_seq_mem_scan_reader: directed and randomized scans checked against an array-based reference
module tb_seq_mem_scan_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] mem_m [16];
  seq_mem_scan_reader_if bus();
  seq_mem_scan_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input int a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic wr_bit(input int a, input int i, input logic v);
    bus.bit_en = 1'b1;
    bus.bit_addr = 4'(a);
    bus.bit_index = 3'(i);
    bus.bit_value = v;
    step();
    bus.bit_en = 1'b0;
    mem_m[a][i] = v;
  endtask

  // ready_pct < 0 selects a fixed 3-cycle stall on the second beat
  task automatic run_scan(input int s, input int len, input int ready_pct, input bit mid_start);
    int n, beats, stalls, cyc;
    int qa[$];
    logic [7:0] qd[$];
    bit seen_done, last_xfer;
    n = (len > 16) ? 16 : len;
    beats = 0; stalls = 0; cyc = 0; seen_done = 0; last_xfer = 0;
    for (int i = 0; i < n; i++) begin
      qa.push_back((s + i) % 16);
      qd.push_back(mem_m[(s + i) % 16]);
    end
    bus.start = 1'b1;
    bus.start_addr = 4'(s);
    bus.length = 5'(len);
    step();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    for (int c = 0; c < 400 && !seen_done; c++) begin
      bus.start = mid_start && (c == 2);
      bus.start_addr = 4'($urandom_range(15));
      bus.length = 5'd5;
      if (bus.out_valid) begin
        if (beats < n) begin
          check("beat_data", bus.out_data, qd[beats]);
          check("beat_addr", bus.out_addr, qa[beats]);
        end else check("extra_valid", bus.out_valid, 0);
      end
      if (last_xfer) check("done_after_last", bus.done, 1);
      last_xfer = 0;
      if (bus.done) begin
        seen_done = 1;
        cyc = c;
        check("beats_at_done", beats, n);
        check("valid_at_done", bus.out_valid, 0);
      end else begin
        if (ready_pct < 0) begin
          bus.out_ready = !(bus.out_valid && beats == 1 && stalls < 3);
          if (!bus.out_ready) stalls++;
        end else bus.out_ready = ($urandom_range(99) < ready_pct);
        if (bus.out_valid && bus.out_ready && beats < n) begin
          check("beat_last", bus.out_last, (beats == n - 1));
          beats++;
          last_xfer = (beats == n);
        end
      end
      step();
    end
    bus.start = 1'b0;
    check("done_seen", seen_done, 1);
    check("done_one_cycle", bus.done, 0);
    check("busy_cleared", bus.busy, 0);
    if (ready_pct == 100) check("scan_cycles", cyc, (n == 0) ? 0 : n + 1);
    if (ready_pct < 0) check("stall_cycles", stalls, 3);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.bit_en = 0; bus.bit_addr = 0; bus.bit_index = 0; bus.bit_value = 0;
    bus.start = 0; bus.start_addr = 0; bus.length = 0; bus.out_ready = 0;
    #2;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_addr", bus.out_addr, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 16; a++) wr_word(a, 8'($urandom));
    wr_word(0, 8'h10); wr_word(1, 8'h21); wr_word(2, 8'h32); wr_word(3, 8'h43);
    run_scan(0, 4, 100, 0);
    run_scan(0, 4, -1, 0);
    wr_word(14, 8'hAA); wr_word(15, 8'hBB); wr_word(0, 8'hCC);
    run_scan(14, 3, 100, 0);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'h00;
    bus.bit_en = 1'b1; bus.bit_addr = 4'd5; bus.bit_index = 3'd7; bus.bit_value = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.bit_en = 1'b0;
    mem_m[5] = 8'h80;
    run_scan(5, 1, 100, 0);
    bus.start = 1'b1; bus.start_addr = 4'd5; bus.length = 5'd1; bus.out_ready = 1'b0;
    step();
    bus.start = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'hFF;
    step();
    bus.wr_en = 1'b0;
    check("rdw_valid", bus.out_valid, 1);
    check("rdw_old_data", bus.out_data, 8'h80);
    mem_m[5] = 8'hFF;
    bus.out_ready = 1'b1;
    step();
    check("rdw_done", bus.done, 1);
    step();
    run_scan(5, 1, 100, 0);
    run_scan(7, 0, 100, 0);
    run_scan(2, 8, 70, 1);
    run_scan(9, 20, 100, 0);
    bus.start = 1'b1; bus.start_addr = 4'd0; bus.length = 5'd4; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("pre_rst_addr", bus.out_addr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    step();
    step();
    check("rst_hold_done", bus.done, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_done", bus.done, 0);
    check("post_rst_valid", bus.out_valid, 0);
    run_scan(0, 4, 100, 0);
    for (int k = 0; k < 8; k++) begin
      wr_word($urandom_range(15), 8'($urandom));
      wr_bit($urandom_range(15), $urandom_range(7), 1'($urandom));
      run_scan($urandom_range(15), $urandom_range(31), $urandom_range(100, 30), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
